vga_timing_gen: RTL and testbench

- Parametrised VGA/LCD raster timing generator, the successor to the fixed 640x480 controller.
- Timing, sync polarity, colour width and pixel-fetch lead are all parameters; adds frame-aligned enable, border fill, and frame/line start strobes.
- Sits between the pixel clock domain and any pixel source (pattern generator, framebuffer reader); drives the display pins.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_timing.sv | 62 ++++++
 rtl/vga_timing_gen.sv | 138 +++++++++++++
 tb/tb_vga_timing_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants, run-control state encoding and segment helpers for the
// parametrised raster timing generator.
package vga_timing_pkg;

  // 640x480@60 with an 8-pixel / 8-line border ring around the active area.
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 40;
  localparam int DEF_H_LEFT  = 8;
  localparam int DEF_H_VALID = 640;
  localparam int DEF_H_RIGHT = 8;
  localparam int DEF_H_FRONT = 8;

  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 25;
  localparam int DEF_V_LEFT  = 8;
  localparam int DEF_V_VALID = 480;
  localparam int DEF_V_RIGHT = 8;
  localparam int DEF_V_FRONT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } run_state_e;

  function automatic int seg_total(input int sync, input int back, input int left,
                                   input int valid, input int right, input int front);
    return sync + back + left + valid + right + front;
  endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// One raster axis: wrapping counter plus sync, border, active and
// request-window decodes for a single set of segment lengths.
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int SYNC  = DEF_H_SYNC,
  parameter int BACK  = DEF_H_BACK,
  parameter int LEFT  = DEF_H_LEFT,
  parameter int VALID = DEF_H_VALID,
  parameter int RIGHT = DEF_H_RIGHT,
  parameter int FRONT = DEF_H_FRONT,
  parameter int LEAD  = 0,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             in_sync,
  output logic             in_border,
  output logic             in_active,
  output logic             in_req
);

  localparam int TOTAL = seg_total(SYNC, BACK, LEFT, VALID, RIGHT, FRONT);

  // Decode bounds carry one extra bit so a window ending at 2^CNT_W still compares correctly.
  localparam logic [CNT_W:0] C_LAST     = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] C_SYNC_END = (CNT_W+1)'(SYNC);
  localparam logic [CNT_W:0] C_BRD_BEG  = (CNT_W+1)'(SYNC + BACK);
  localparam logic [CNT_W:0] C_ACT_BEG  = (CNT_W+1)'(SYNC + BACK + LEFT);
  localparam logic [CNT_W:0] C_ACT_END  = (CNT_W+1)'(SYNC + BACK + LEFT + VALID);
  localparam logic [CNT_W:0] C_BRD_END  = (CNT_W+1)'(SYNC + BACK + LEFT + VALID + RIGHT);
  localparam logic [CNT_W:0] C_REQ_BEG  = (CNT_W+1)'(SYNC + BACK + LEFT - LEAD);
  localparam logic [CNT_W:0] C_REQ_END  = (CNT_W+1)'(SYNC + BACK + LEFT + VALID - LEAD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_x;

  assign cnt_x = {1'b0, cnt_q};
  assign cnt   = cnt_q;
  assign last  = (cnt_x == C_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run)     cnt_d = '0;
    else if (adv) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign in_sync   = (cnt_x < C_SYNC_END);
  assign in_border = (cnt_x >= C_BRD_BEG) && (cnt_x < C_BRD_END);
  assign in_active = (cnt_x >= C_ACT_BEG) && (cnt_x < C_ACT_END);
  assign in_req    = (cnt_x >= C_REQ_BEG) && (cnt_x < C_REQ_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/LCD raster timing generator with frame-aligned run control,
// lead-compensated pixel requests, border fill and frame/line strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int              H_SYNC     = DEF_H_SYNC,
  parameter int              H_BACK     = DEF_H_BACK,
  parameter int              H_LEFT     = DEF_H_LEFT,
  parameter int              H_VALID    = DEF_H_VALID,
  parameter int              H_RIGHT    = DEF_H_RIGHT,
  parameter int              H_FRONT    = DEF_H_FRONT,
  parameter int              V_SYNC     = DEF_V_SYNC,
  parameter int              V_BACK     = DEF_V_BACK,
  parameter int              V_LEFT     = DEF_V_LEFT,
  parameter int              V_VALID    = DEF_V_VALID,
  parameter int              V_RIGHT    = DEF_V_RIGHT,
  parameter int              V_FRONT    = DEF_V_FRONT,
  parameter int              CNT_W      = 10,
  parameter int              RGB_W      = 16,
  parameter int              REQ_LAT    = 1,
  parameter bit              H_POL      = 1'b1,
  parameter bit              V_POL      = 1'b1,
  parameter logic [RGB_W-1:0] BORDER_RGB = '0
) (
  input  logic             vga_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [RGB_W-1:0] pix_data,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_start,
  output logic             line_start
);

  localparam logic [CNT_W-1:0] REQ_BEG = CNT_W'(H_SYNC + H_BACK + H_LEFT - REQ_LAT);
  localparam logic [CNT_W-1:0] VA0     = CNT_W'(V_SYNC + V_BACK + V_LEFT);

  run_state_e state_q, state_d;
  logic       run;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_last, h_sync, h_brd, h_act, h_req;
  logic v_last, v_sync, v_brd, v_act, v_req;

  assign run = (state_q != ST_IDLE);

  vga_axis_timing #(
    .SYNC(H_SYNC), .BACK(H_BACK), .LEFT(H_LEFT), .VALID(H_VALID),
    .RIGHT(H_RIGHT), .FRONT(H_FRONT), .LEAD(REQ_LAT), .CNT_W(CNT_W)
  ) u_h (
    .clk(vga_clk), .rst(sys_rst), .run(run), .adv(1'b1),
    .cnt(h_cnt), .last(h_last), .in_sync(h_sync), .in_border(h_brd),
    .in_active(h_act), .in_req(h_req)
  );

  vga_axis_timing #(
    .SYNC(V_SYNC), .BACK(V_BACK), .LEFT(V_LEFT), .VALID(V_VALID),
    .RIGHT(V_RIGHT), .FRONT(V_FRONT), .LEAD(0), .CNT_W(CNT_W)
  ) u_v (
    .clk(vga_clk), .rst(sys_rst), .run(run), .adv(h_last),
    .cnt(v_cnt), .last(v_last), .in_sync(v_sync), .in_border(v_brd),
    .in_active(v_act), .in_req(v_req)
  );

  // Leaving IDLE only happens on a frame boundary so the raster is never cut short.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: if (en) state_d = ST_RUN;
                else if (h_last && v_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign pix_req = run && !sys_rst && h_req && v_req;
  assign pix_x   = pix_req ? h_cnt - REQ_BEG : '1;
  assign pix_y   = pix_req ? v_cnt - VA0     : '1;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             fs_q, fs_d;
  logic             ls_q, ls_d;

  always_comb begin
    hsync_d = !H_POL;
    vsync_d = !V_POL;
    de_d    = 1'b0;
    rgb_d   = '0;
    fs_d    = 1'b0;
    ls_d    = 1'b0;
    if (run) begin
      hsync_d = h_sync ? H_POL : !H_POL;
      vsync_d = v_sync ? V_POL : !V_POL;
      de_d    = h_act && v_act;
      if (de_d)                rgb_d = pix_data;
      else if (h_brd && v_brd) rgb_d = BORDER_RGB;
      ls_d = (h_cnt == '0);
      fs_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      hsync_q <= !H_POL;
      vsync_q <= !V_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 20x11 raster (active 8x4, border ring 12x6).
// Expected pixels are queued ahead of each frame; a monitor pops one per de cycle.
module tb_vga_timing_gen;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        en      = 1'b0;
  logic [15:0] pix_data;
  logic        pix_req;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, de;
  logic [15:0] rgb;
  logic        frame_start, line_start;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] d1 = '0, d2 = '0, d3 = '0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_LEFT(2), .H_VALID(8), .H_RIGHT(2), .H_FRONT(1),
    .V_SYNC(2), .V_BACK(2), .V_LEFT(1), .V_VALID(4), .V_RIGHT(1), .V_FRONT(1),
    .CNT_W(10), .RGB_W(16), .REQ_LAT(3), .H_POL(1'b1), .V_POL(1'b1),
    .BORDER_RGB(16'hF800)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .en(en), .pix_data(pix_data),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .de(de), .rgb(rgb), .frame_start(frame_start), .line_start(line_start)
  );

  // Pixel source: 3-clock delay of the requested coordinate.
  always @(posedge vga_clk) begin
    d1 <= pix_req ? {pix_y[5:0], pix_x} : 16'h0;
    d2 <= d1;
    d3 <= d2;
  end
  assign pix_data = d3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string name);
    chk(name, {hsync, vsync, de, rgb, frame_start, line_start, pix_req, pix_x, pix_y},
        {1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h3FF});
  endtask

  task automatic push_pixels(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'(((i / 8) << 10) | (i % 8)));
  endtask

  task automatic wait_fs(input string name, input int max);
    int n;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge vga_clk);
      if (frame_start === 1'b1) begin
        n = i;
        break;
      end
    end
    chk(name, 64'(n), 64'd2);
  endtask

  // Entered at the negedge showing frame_start; k is the raster position of the outputs.
  task automatic run_frame(input int drop_k, input int raise_k);
    int hs_n, vs_n, de_n, bd_n, fs_n, ls_n;
    hs_n = 0; vs_n = 0; de_n = 0; bd_n = 0; fs_n = 0; ls_n = 0;
    for (int k = 0; k < 220; k++) begin
      if (hsync === 1'b1) hs_n++;
      if (vsync === 1'b1) vs_n++;
      if (de === 1'b1) de_n++;
      if (de === 1'b0 && rgb === 16'hF800) bd_n++;
      if (frame_start === 1'b1) fs_n++;
      if (line_start === 1'b1) ls_n++;
      case (k)
        0:   chk("start_k0", {frame_start, line_start, hsync, vsync}, 4'hF);
        3:   chk("hsync_last", hsync, 1'b1);
        4:   chk("hsync_off", hsync, 1'b0);
        20:  chk("line2_strobes", {frame_start, line_start}, 2'b01);
        39:  chk("vsync_last", vsync, 1'b1);
        40:  chk("vsync_off", vsync, 1'b0);
        86:  chk("pre_border", rgb, 16'h0);
        87:  chk("top_border_first", rgb, 16'hF800);
        98:  chk("top_border_last", rgb, 16'hF800);
        99:  chk("post_border", rgb, 16'h0);
        104: chk("req_before", {pix_req, pix_x, pix_y}, {1'b0, 10'h3FF, 10'h3FF});
        105: chk("req_first", {pix_req, pix_x, pix_y}, {1'b1, 10'd0, 10'd0});
        108: chk("left_border", {de, rgb}, {1'b0, 16'hF800});
        109: chk("de_first", de, 1'b1);
        116: chk("de_last", de, 1'b1);
        117: chk("right_border", {de, rgb}, {1'b0, 16'hF800});
        172: chk("req_last", {pix_req, pix_x, pix_y}, {1'b1, 10'd7, 10'd3});
        173: chk("req_after", pix_req, 1'b0);
        219: chk("front_porch", {hsync, vsync, de, rgb}, 19'h0);
        default: ;
      endcase
      if (k == drop_k)  en = 1'b0;
      if (k == raise_k) en = 1'b1;
      @(negedge vga_clk);
    end
    chk("hsync_count", 64'(hs_n), 64'd44);
    chk("vsync_count", 64'(vs_n), 64'd40);
    chk("de_count", 64'(de_n), 64'd32);
    chk("border_count", 64'(bd_n), 64'd40);
    chk("fs_count", 64'(fs_n), 64'd1);
    chk("ls_count", 64'(ls_n), 64'd11);
  endtask

  // Scoreboard monitor: every displayed pixel must match the next queued one.
  always @(negedge vga_clk) begin
    if (de === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected: rgb=%0h with nothing queued (t=%0t)", rgb, $time);
      end else begin
        chk("pixel", 64'(rgb), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge vga_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge vga_clk);
      chk_idle("idle_hold");
    end

    en = 1'b1;
    wait_fs("fs_latency", 8);
    push_pixels(32);
    run_frame(-1, -1);
    push_pixels(32);
    run_frame(60, 150);
    push_pixels(32);
    run_frame(30, -1);
    for (int i = 0; i < 10; i++) begin
      chk_idle("post_drain");
      @(negedge vga_clk);
    end

    // Mid-frame reset at counters (10,6) with en held high.
    en = 1'b1;
    wait_fs("fs_latency2", 8);
    push_pixels(9);
    for (int k = 0; k < 129; k++) @(negedge vga_clk);
    sys_rst = 1'b1;
    #1;
    chk("rst_comb", {pix_req, pix_x, pix_y}, {1'b0, 10'h3FF, 10'h3FF});
    @(negedge vga_clk);
    chk_idle("rst_idle");
    sys_rst = 1'b0;
    @(negedge vga_clk);
    chk("rst_wait", {frame_start, de}, 2'b00);
    @(negedge vga_clk);
    chk("restart_fs", {frame_start, line_start, hsync, vsync}, 4'hF);
    push_pixels(32);
    run_frame(0, -1);
    for (int i = 0; i < 5; i++) begin
      chk_idle("final_idle");
      @(negedge vga_clk);
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
